// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_fetch_ctrl_pkg : shared widths, reset PC and fetch-controller state type
// Revision 1.0
// ----------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } fetch_state_e;

endpackage : pc_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_fetch_ctrl : single-issue fetch/execute sequencer owning PC and retire count
// Revision 1.0
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid,
  input  logic              ifu_req_ready,
  output logic [XLEN-1:0]   ifu_req_addr,
  input  logic              ifu_resp_valid,
  input  logic [INST_W-1:0] ifu_resp_inst,
  input  logic              ifu_resp_err,
  output logic [XLEN-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              exu_done,
  input  logic [XLEN-1:0]   next_pc,
  input  logic              halt,
  output logic              halted,
  output logic              fault,
  output logic [XLEN-1:0]   retired
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   retired_q, retired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (ifu_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            state_d = ST_FAULT;
          end else begin
            inst_d  = ifu_resp_inst;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // halt wins over a misaligned target: ebreak retires regardless of next_pc
        if (exu_done) begin
          if (halt) begin
            retired_d = retired_q + 64'd1;
            state_d   = ST_HALTED;
          end else if (next_pc[1]) begin
            state_d = ST_FAULT;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 64'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign ifu_req_valid = (state_q == ST_FETCH);
  assign ifu_req_addr  = pc_q;
  assign inst_valid    = (state_q == ST_EXEC);
  assign halted        = (state_q == ST_HALTED);
  assign fault         = (state_q == ST_FAULT);
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign retired       = retired_q;

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000000080000000, PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ifu_req_valid  out  1  fetch request valid.
REQ-005 ifu_req_ready  in  1  instruction memory accepts the request.
REQ-006 ifu_req_addr  out  64  fetch address, equal to pc.
REQ-007 ifu_resp_valid  in  1  fetch response valid.
REQ-008 ifu_resp_inst  in  32  fetched instruction.
REQ-009 ifu_resp_err  in  1  fetch access fault, qualified by ifu_resp_valid.
REQ-010 pc  out  64  current PC.
REQ-011 inst  out  32  latched instruction for decode/execute.
REQ-012 inst_valid  out  1  inst is valid and executing.
REQ-013 exu_done  in  1  execute finished; next_pc is valid this cycle.
REQ-014 next_pc  in  64  next PC from the next-PC generator, bit0 already cleared.
REQ-015 halt  in  1  current instruction is ebreak; qualified by exu_done.
REQ-016 halted  out  1  sticky halt indication.
REQ-017 fault  out  1  sticky fault indication.
REQ-018 retired  out  64  count of retired instructions.

Function
REQ-019 States SHALL be IDLE, FETCH, WAIT, EXEC, HALTED and FAULT, with a one-hot or binary encoding.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-021 FETCH: ifu_req_valid=1 and ifu_req_addr=pc, both held stable until ifu_req_ready=1; on that handshake the state goes to WAIT.
REQ-022 WAIT: on ifu_resp_valid=1 with ifu_resp_err=0, inst<=ifu_resp_inst and the state goes to EXEC; with ifu_resp_err=1, the state goes to FAULT and inst is unchanged.
REQ-023 ifu_resp_valid SHALL be ignored in every state other than WAIT, including the handshake cycle in FETCH.
REQ-024 EXEC: inst_valid=1 and inst/pc stable; exu_done=0 holds the EXEC state indefinitely.
REQ-025 EXEC with exu_done=1, halt=0 and next_pc[1]=0: pc<=next_pc, retired<=retired+1, next state FETCH.
REQ-026 EXEC with exu_done=1 and halt=1: retired<=retired+1, pc unchanged, next state HALTED; halt takes priority over a misaligned next_pc.
REQ-027 EXEC with exu_done=1, halt=0 and next_pc[1]=1: misaligned target, no C extension; next state FAULT, pc and retired unchanged.
REQ-028 HALTED and FAULT SHALL be terminal until rst; halted=1 or fault=1 respectively; ifu_req_valid=0 and inst_valid=0.
REQ-029 retired SHALL wrap modulo 2^64 with no saturation.
REQ-030 ifu_req_valid and inst_valid SHALL never be 1 in the same cycle.
REQ-031 Latency: the minimum PC-to-PC period is 3 cycles (FETCH, WAIT and EXEC each one cycle).

Reset
REQ-032 On rst assertion, even mid-request: state=IDLE, pc=RESET_PC, inst=32'h0, retired=0, all valid/halted/fault outputs=0, applied asynchronously.
REQ-033 An outstanding memory response arriving after reset SHALL be discarded, because the state is not WAIT.

Structure
REQ-034 State encoding, RESET_PC default and the inst width constant SHALL live in the shared npc package.
REQ-035 The block is a single module with no sub-modules; next-PC arithmetic stays outside it, in the existing next-PC generator.

Verification
REQ-036 Reset release, ready=1, response after 1 cycle with inst 32'h00000013, exu_done with next_pc=0x80000004 -> addr 0x80000000 then 0x80000004; retired=1.
REQ-037 Hold ifu_req_ready=0 for 5 cycles -> ifu_req_valid stays 1 and addr stays 0x80000000 throughout; WAIT entered only after ready=1.
REQ-038 ifu_resp_err=1 in WAIT -> fault=1 next cycle, no further requests, pc unchanged.
REQ-039 exu_done with halt=1 and next_pc=0x80000002 -> halted=1, fault=0, retired incremented.
REQ-040 exu_done with next_pc=0x80000006, halt=0 -> fault=1 and retired unchanged.
REQ-041 rst asserted during WAIT, then a late ifu_resp_valid -> response ignored; the first request after reset release is to 0x80000000.
